sync_fifo_ext: RTL and testbench
================================

# sync_fifo_ext

Single-clock, parametrised FIFO; the next generation of the team's synchronous FIFO. Adds selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits between producer and consumer stages in one clock domain and holds its storage internally as a register array.

## Interface
- DATA_WIDTH, 32, word width in bits
- DATA_DEPTH, 128, capacity in words; power of two, >= 4
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AFULL_THRESH, DATA_DEPTH-4, almost_full_o asserts when count_o >= this value; 1..DATA_DEPTH
- AEMPTY_THRESH, 4, almost_empty_o asserts when count_o <= this value; 0..DATA_DEPTH-1

- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write data
- rd_en_i  in  1  read request (standard) / pop acknowledge (FWFT)
- rd_data_o  out  DATA_WIDTH  read data
- rd_valid_o  out  1  rd_data_o holds a valid word (see Operation)
- full_o  out  1  count_o == DATA_DEPTH
- empty_o  out  1  no word available to the reader
- almost_full_o  out  1  count_o >= AFULL_THRESH
- almost_empty_o  out  1  count_o <= AEMPTY_THRESH
- count_o  out  $clog2(DATA_DEPTH)+1  words held, including the FWFT output register
- overflow_o  out  1  sticky: a write was dropped
- underflow_o  out  1  sticky: a read was rejected
- clr_err_i  in  1  synchronous clear of overflow_o and underflow_o

## Operation
- Pointers are $clog2(DATA_DEPTH)+1 bits; the low bits address storage, and the MSB disambiguates full from empty. Pointers wrap naturally at 2*DATA_DEPTH.
- Read accept (rd_acc): standard mode = rd_en_i && !empty_o; FWFT = rd_en_i && rd_valid_o.
- Write accept (wr_acc) = wr_en_i && (!full_o || rd_acc). A write at full is accepted when a read is accepted in the same cycle.
- count_o next = count_o + wr_acc - rd_acc. Capacity is exactly DATA_DEPTH in both modes.
- All status outputs are decoded from registers only. There is no combinational path from inputs to outputs.
- Standard mode: empty_o = (count_o == 0). On rd_acc in cycle t, rd_data_o = head word and rd_valid_o = 1 in cycle t+1. rd_valid_o is a 1-cycle pulse; rd_data_o holds its value until the next rd_acc.
- FWFT mode: an output register holds the head word. rd_valid_o = 1 while it is loaded, and empty_o = !rd_valid_o. The register loads from storage whenever it is empty, or is being popped, and storage is non-empty.
- Simultaneous read and write at empty: the read is rejected (underflow) and the write is accepted.
- Overflow: wr_en_i && full_o && !rd_acc. The write is dropped, storage is unchanged, and overflow_o = 1 from the next cycle.
- Underflow: rd_en_i && !rd_acc. Pointers are unchanged, and underflow_o = 1 from the next cycle.
- Error flags stay set until clr_err_i, which clears them at the next edge. If an error and clr_err_i coincide, the set wins.
- Reset (asynchronous, any time): pointers and count_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0, rd_valid_o = 0, rd_data_o = 0, overflow_o = 0, underflow_o = 0. Storage contents are not cleared, and in-flight words are discarded.

## Timing
- Write accepted in cycle t: count_o, full_o and almost_* update in cycle t+1.
- Standard read latency: 1 cycle from rd_acc to rd_data_o.
- FWFT first-word latency: a write into an empty FIFO in cycle t gives rd_valid_o = 1 with that word in cycle t+2. The word enters storage at t+1 and is prefetched at t+2. count_o rises at t+1, so empty_o lags count_o by one cycle.
- FWFT back-to-back pops: with storage non-empty, rd_valid_o stays 1 and the next word appears in the cycle after the pop.
- Sustained throughput is one write and one read per cycle in both modes.

## Test plan
- Standard mode, DEPTH=8: write 0x1..0x8 -> full_o=1, count_o=8, almost_full_o=1 from count 4. Read 8 -> data 0x1..0x8 each one cycle after rd_en_i, then empty_o=1.
- Overflow/underflow: write a 9th word at full -> overflow_o=1, the word is not stored. Read at empty -> underflow_o=1. clr_err_i pulse -> both flags 0 next cycle.
- Simultaneous read and write at full -> both accepted, count_o stays 8, no overflow. Simultaneous at empty -> write only, underflow_o=1, count_o=1.
- FWFT=1: write 0xA5 into empty in cycle t -> rd_valid_o=1, rd_data_o=0xA5 at t+2. Pop with 3 words queued -> next word is visible the cycle after each pop.
- Wrap-around: run 3*DEPTH continuous write/read traffic with random stalls -> in-order data, count_o matches a reference model, no spurious full/empty.
- Assert reset_n mid-burst with count_o=5 -> all outputs take their reset values immediately, without waiting for a clock edge. After release, a fresh write/read works.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// -----------------------------------------------------------------------------
// sync_fifo_ext
//
// Single-clock parametrised FIFO with a register-array store. It offers either
// a standard registered read or a first-word-fall-through (FWFT) read, an
// occupancy count, programmable almost-full/almost-empty flags and sticky
// overflow/underflow error flags.
//
// Parameters
//   DATA_WIDTH    word width in bits
//   DATA_DEPTH    capacity in words (power of two, >= 4)
//   FWFT          0 = standard registered read, 1 = first-word-fall-through
//   AFULL_THRESH  almost_full_o  when count_o >= AFULL_THRESH  (1..DATA_DEPTH)
//   AEMPTY_THRESH almost_empty_o when count_o <= AEMPTY_THRESH (0..DATA_DEPTH-1)
//
// Ports
//   clk            rising-edge clock for all logic
//   reset_n        asynchronous active-low reset
//   wr_en_i        write request
//   wr_data_i      write data
//   rd_en_i        read request (standard) / pop acknowledge (FWFT)
//   rd_data_o      read data
//   rd_valid_o     standard: one-cycle pulse after an accepted read
//                  FWFT: high while the output register holds the head word
//   full_o         count_o == DATA_DEPTH
//   empty_o        no word available to the reader
//   almost_full_o  count_o >= AFULL_THRESH
//   almost_empty_o count_o <= AEMPTY_THRESH
//   count_o        words held, including the FWFT output register
//   overflow_o     sticky: a write was dropped
//   underflow_o    sticky: a read was rejected
//   clr_err_i      synchronous clear of overflow_o / underflow_o
//
// All outputs are registers or decodes of registers; nothing combinational
// runs from an input to an output.
// -----------------------------------------------------------------------------
module sync_fifo_ext #(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 128,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DATA_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_en_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic                        rd_valid_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
  output logic [$clog2(DATA_DEPTH):0] count_o,
  output logic                        overflow_o,
  output logic                        underflow_o,
  input  logic                        clr_err_i
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam bit            FWFT_MODE = (FWFT != 0);

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q,      ovf_d;
  logic                  unf_q,      unf_d;

  // Decoded control
  logic                  full_w;
  logic                  empty_w;
  logic [PW-1:0]         stor_cnt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  load;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic [DATA_WIDTH-1:0] head_word;

  assign full_w  = (count_q == DEPTH_C);

  // In FWFT mode the reader only sees the output register, so emptiness
  // follows its valid bit and lags count_q by a cycle on the first write.
  assign empty_w = FWFT_MODE ? !rd_valid_q : (count_q == '0);

  // Words sitting in the array; in FWFT mode this excludes the output register.
  assign stor_cnt = wr_ptr_q - rd_ptr_q;

  assign rd_acc = FWFT_MODE ? (rd_en_i && rd_valid_q) : (rd_en_i && !empty_w);

  // A write at full is allowed when a read frees a slot in the same cycle.
  assign wr_acc = wr_en_i && (!full_w || rd_acc);

  // Array read: standard mode on every accepted read; FWFT mode whenever the
  // output register is free (or being freed) and the array has a word.
  assign load = FWFT_MODE ? ((!rd_valid_q || rd_acc) && (stor_cnt != '0))
                          : rd_acc;

  assign ovf_evt = wr_en_i && full_w && !rd_acc;
  assign unf_evt = rd_en_i && !rd_acc;

  assign head_word = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d  = rd_ptr_q + PW'(load);
    count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
    rd_data_d = load ? head_word : rd_data_q;

    if (FWFT_MODE) begin
      rd_valid_d = load || (rd_valid_q && !rd_acc);
    end else begin
      rd_valid_d = rd_acc;
    end

    // Setting an error wins over a coincident clear.
    ovf_d = ovf_evt || (ovf_q && !clr_err_i);
    unf_d = unf_evt || (unf_q && !clr_err_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Array contents are not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign full_o         = full_w;
  assign empty_o        = empty_w;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ext
//
// Drives one standard-mode and one FWFT-mode sync_fifo_ext (DEPTH 8) with the
// same input stream. A queue-based reference model per mode updates on each
// clock edge; a monitor on the falling edge compares the DUT outputs with it.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ext;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFT   = 4;
  localparam int AET   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_err;

  logic [DW-1:0] s_data,  f_data;
  logic          s_valid, f_valid;
  logic          s_full,  f_full;
  logic          s_empty, f_empty;
  logic          s_afull, f_afull;
  logic          s_aempty, f_aempty;
  logic [CW-1:0] s_count, f_count;
  logic          s_ovf,   f_ovf;
  logic          s_unf,   f_unf;

  sync_fifo_ext #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(0),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) u_std (
    .clk(clk), .reset_n(reset_n),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(s_data), .rd_valid_o(s_valid),
    .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_afull), .almost_empty_o(s_aempty),
    .count_o(s_count), .overflow_o(s_ovf), .underflow_o(s_unf),
    .clr_err_i(clr_err)
  );

  sync_fifo_ext #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1),
    .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) u_fwft (
    .clk(clk), .reset_n(reset_n),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(f_data), .rd_valid_o(f_valid),
    .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty),
    .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_unf),
    .clr_err_i(clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Standard mode: words held in sq; a read accepted in cycle c delivers its
  // word in cycle c+1 (exp_std is the scoreboard of pending deliveries).
  // FWFT mode: each word carries the cycle it was written; the head is visible
  // from max(write cycle + 2, previous pop cycle + 1).
  typedef struct {
    logic [31:0] d;
    int          w;
  } fent_t;

  logic [31:0] sq[$];
  logic [31:0] exp_std[$];
  fent_t       fq[$];
  fent_t       fe;
  int          cyc        = 0;
  int          f_last_pop = -1000;
  bit          s_ovf_m = 0, s_unf_m = 0, f_ovf_m = 0, f_unf_m = 0;
  bit          s_ra, s_wa, f_ra, f_wa;

  function automatic bit f_vis(input int c);
    int v;
    if (fq.size() == 0) return 1'b0;
    v = fq[0].w + 2;
    if (f_last_pop + 1 > v) v = f_last_pop + 1;
    return (c >= v);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq.delete();
      exp_std.delete();
      fq.delete();
      f_last_pop = -1000;
      s_ovf_m = 0; s_unf_m = 0; f_ovf_m = 0; f_unf_m = 0;
    end else begin
      s_ra = rd_en && (sq.size() > 0);
      s_wa = wr_en && ((sq.size() < DEPTH) || s_ra);
      s_ovf_m = (s_ovf_m && !clr_err) || (wr_en && (sq.size() == DEPTH) && !s_ra);
      s_unf_m = (s_unf_m && !clr_err) || (rd_en && !s_ra);
      if (s_ra) exp_std.push_back(sq.pop_front());
      if (s_wa) sq.push_back(wr_data);

      f_ra = rd_en && f_vis(cyc);
      f_wa = wr_en && ((fq.size() < DEPTH) || f_ra);
      f_ovf_m = (f_ovf_m && !clr_err) || (wr_en && (fq.size() == DEPTH) && !f_ra);
      f_unf_m = (f_unf_m && !clr_err) || (rd_en && !f_ra);
      if (f_ra) begin
        void'(fq.pop_front());
        f_last_pop = cyc;
      end
      if (f_wa) begin
        fe.d = wr_data;
        fe.w = cyc;
        fq.push_back(fe);
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] m_word;
  bit          m_vis;

  always @(negedge clk) begin
    if (exp_std.size() > 0) begin
      m_word = exp_std.pop_front();
      chk("std_rd_valid", 32'(s_valid), 32'd1);
      chk("std_rd_data", s_data, m_word);
    end else begin
      chk("std_rd_valid", 32'(s_valid), 32'd0);
    end
    chk("std_count",  32'(s_count),  32'(sq.size()));
    chk("std_full",   32'(s_full),   32'(sq.size() == DEPTH));
    chk("std_empty",  32'(s_empty),  32'(sq.size() == 0));
    chk("std_afull",  32'(s_afull),  32'(sq.size() >= AFT));
    chk("std_aempty", 32'(s_aempty), 32'(sq.size() <= AET));
    chk("std_ovf",    32'(s_ovf),    32'(s_ovf_m));
    chk("std_unf",    32'(s_unf),    32'(s_unf_m));

    m_vis = f_vis(cyc);
    chk("fwft_rd_valid", 32'(f_valid), 32'(m_vis));
    if (m_vis) chk("fwft_rd_data", f_data, fq[0].d);
    chk("fwft_count",  32'(f_count),  32'(fq.size()));
    chk("fwft_full",   32'(f_full),   32'(fq.size() == DEPTH));
    chk("fwft_empty",  32'(f_empty),  32'(!m_vis));
    chk("fwft_afull",  32'(f_afull),  32'(fq.size() >= AFT));
    chk("fwft_aempty", 32'(f_aempty), 32'(fq.size() <= AET));
    chk("fwft_ovf",    32'(f_ovf),    32'(f_ovf_m));
    chk("fwft_unf",    32'(f_unf),    32'(f_unf_m));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit we, input logic [31:0] wd, input bit re, input bit clr);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_std_count"},  32'(s_count),  32'd0);
    chk({tag, "_std_empty"},  32'(s_empty),  32'd1);
    chk({tag, "_std_aempty"}, 32'(s_aempty), 32'd1);
    chk({tag, "_std_full"},   32'(s_full),   32'd0);
    chk({tag, "_std_afull"},  32'(s_afull),  32'd0);
    chk({tag, "_std_valid"},  32'(s_valid),  32'd0);
    chk({tag, "_std_data"},   s_data,        32'd0);
    chk({tag, "_std_errs"},   32'({s_ovf, s_unf}), 32'd0);
    chk({tag, "_fwft_count"}, 32'(f_count),  32'd0);
    chk({tag, "_fwft_empty"}, 32'(f_empty),  32'd1);
    chk({tag, "_fwft_aempty"},32'(f_aempty), 32'd1);
    chk({tag, "_fwft_full"},  32'(f_full),   32'd0);
    chk({tag, "_fwft_valid"}, 32'(f_valid),  32'd0);
    chk({tag, "_fwft_data"},  f_data,        32'd0);
    chk({tag, "_fwft_errs"},  32'({f_ovf, f_unf}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] bw;
  int          wp;

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Fill to full with 1..8; almost_full from count 4.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      chk("fill_std_afull", 32'(s_afull), 32'(i >= AFT));
      chk("fill_std_count", 32'(s_count), 32'(i));
    end
    chk("fill_std_full",  32'(s_full),  32'd1);
    chk("fill_fwft_full", 32'(f_full),  32'd1);
    chk("fill_fwft_count", 32'(f_count), 32'd8);

    // Ninth write at full is dropped.
    drive(1'b1, 32'h9, 1'b0, 1'b0);
    chk("ovf_std_flag",  32'(s_ovf),   32'd1);
    chk("ovf_fwft_flag", 32'(f_ovf),   32'd1);
    chk("ovf_std_count", 32'(s_count), 32'd8);

    // Drain; standard data appears the cycle after each request.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_std_valid", 32'(s_valid), 32'd1);
      chk("drain_std_data",  s_data,       32'(i));
    end
    chk("drain_std_empty", 32'(s_empty), 32'd1);

    // Read at empty, then clear errors.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("unf_std_flag",  32'(s_unf),   32'd1);
    chk("unf_fwft_flag", 32'(f_unf),   32'd1);
    chk("unf_std_valid", 32'(s_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_std_errs",  32'({s_ovf, s_unf}), 32'd0);
    chk("clr_fwft_errs", 32'({f_ovf, f_unf}), 32'd0);

    // Simultaneous read and write at full.
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h99, 1'b1, 1'b0);
    chk("rwfull_std_count",  32'(s_count), 32'd8);
    chk("rwfull_std_ovf",    32'(s_ovf),   32'd0);
    chk("rwfull_fwft_count", 32'(f_count), 32'd8);
    chk("rwfull_fwft_ovf",   32'(f_ovf),   32'd0);
    repeat (DEPTH) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Simultaneous read and write at empty: write only, read rejected.
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    chk("rwempty_std_count",  32'(s_count), 32'd1);
    chk("rwempty_std_unf",    32'(s_unf),   32'd1);
    chk("rwempty_fwft_count", 32'(f_count), 32'd1);
    chk("rwempty_fwft_unf",   32'(f_unf),   32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // FWFT first-word latency and back-to-back pops.
    drive(1'b1, 32'hA5, 1'b0, 1'b0);
    chk("fwft_t1_valid", 32'(f_valid), 32'd0);
    chk("fwft_t1_count", 32'(f_count), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fwft_t2_valid", 32'(f_valid), 32'd1);
    chk("fwft_t2_data",  f_data,       32'hA5);
    for (int k = 0; k < 3; k++) drive(1'b1, 32'hB1 + 32'(k), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      if (k < 3) begin
        bw = 32'hB1 + 32'(k);
        chk("fwft_pop_valid", 32'(f_valid), 32'd1);
        chk("fwft_pop_data",  f_data,       bw);
      end else begin
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Random traffic: write-heavy, balanced, then read-heavy.
    for (int i = 0; i < 240; i++) begin
      wp = (i < 80) ? 70 : ((i < 160) ? 50 : 30);
      drive($urandom_range(0, 99) < wp, $urandom,
            $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 99) < 3);
    end
    repeat (12) drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-burst with five words held.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    chk("mid_std_count",  32'(s_count), 32'd5);
    chk("mid_fwft_count", 32'(f_count), 32'd5);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 32'hC0DE, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_std_valid", 32'(s_valid), 32'd1);
    chk("post_std_data",  s_data,       32'hC0DE);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("end_std_pending", 32'(exp_std.size()), 32'd0);
    chk("end_fwft_held",   32'(f_count),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
